// File: rtl/sub64_rr_arbiter_if.sv
// Request/result bundle between the channel filters and the shared subtractor.
// Latency: none (wires only).
// Backpressure: res_ready stalls the result slot, which in turn withholds every req_ready.
interface sub64_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_in1;
    logic [NUM_REQ*64-1:0] req_in2;
    logic                  res_valid;
    logic                  res_ready;
    logic [63:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ovf;
    logic [CNT_W-1:0]      ovf_count;
    logic                  ovf_clr;

    // Requester / downstream side
    modport master (
        output req_valid, req_in1, req_in2, res_ready, ovf_clr,
        input  req_ready, res_valid, res_data, res_id, res_ovf, ovf_count
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_in1, req_in2, res_ready, ovf_clr,
        output req_ready, res_valid, res_data, res_id, res_ovf, ovf_count
    );
endinterface

// File: rtl/sub64_rr_arbiter.sv
// Round-robin shared 64-bit signed subtractor with overflow flag, optional saturation and overflow counter.
// Latency: 1 cycle from accept to res_valid; one result per cycle with res_ready held high.
// Backpressure: while a result is held (res_valid & !res_ready) no requester is granted.
module sub64_rr_arbiter #(
    parameter int NUM_REQ  = 4,   // 2..8
    parameter int ID_W     = 2,   // 2**ID_W must cover NUM_REQ
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub64_rr_arbiter_if.slave    bus
);

    localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] win_hi;
    logic [ID_W-1:0] win_lo;
    logic            found_hi;
    logic            found_lo;
    logic            slot_free;
    logic            accept;
    logic [63:0]     in1_w;
    logic [63:0]     in2_w;
    logic [63:0]     raw;
    logic            ovf;
    logic [63:0]     res_next;
    logic [ID_W-1:0] ptr_next;

    // Winner search: lowest valid index at or above rr_ptr, else lowest valid index overall (wrap).
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_lo   = ID_W'(i);
                found_lo = 1'b1;
                if (ID_W'(i) >= rr_ptr) begin
                    win_hi   = ID_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    // The slot frees up when empty or when the held result is being taken this cycle.
    assign slot_free = !bus.res_valid || bus.res_ready;
    // Reset gating keeps grants off while rst_n is low.
    assign accept    = found_lo && slot_free && rst_n;

    // Grant only the winner; others see ready low.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        in1_w = '0;
        in2_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                in1_w = bus.req_in1[64*i +: 64];
                in2_w = bus.req_in2[64*i +: 64];
            end
        end
    end

    // Overflow only possible when operand signs differ and the wrapped result flips away from in1's sign.
    assign raw      = in1_w - in2_w;
    assign ovf      = (in1_w[63] != in2_w[63]) && (raw[63] != in1_w[63]);
    assign res_next = ((SATURATE != 0) && ovf) ? (in1_w[63] ? MIN_NEG : MAX_POS) : raw;
    assign ptr_next = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // Result slot and round-robin pointer; data/id/ovf hold when the slot drains with no new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
            bus.res_ovf   <= 1'b0;
            rr_ptr        <= '0;
        end else if (accept) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= res_next;
            bus.res_id    <= win;
            bus.res_ovf   <= ovf;
            rr_ptr        <= ptr_next;
        end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
        end
    end

    // Saturating overflow event counter; clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf_count <= '0;
        end else if (bus.ovf_clr) begin
            bus.ovf_count <= '0;
        end else if (accept && ovf && (bus.ovf_count != {CNT_W{1'b1}})) begin
            bus.ovf_count <= bus.ovf_count + 1'b1;
        end
    end

endmodule
